// File: rtl/ahb_apb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_pkg
//
// Shared definitions for the parametrised AHB-Lite to APB bridge:
//   - AHB htrans / hresp encodings
//   - bridge FSM state type
//   - selWidth(): width of the slave-index field carved out of haddr
// No ports; imported by ahb_apb_decode and ahb_apb_bridge_p.
// ---------------------------------------------------------------------------
package ahb_apb_bridge_pkg;

  // AHB transfer types. Only NONSEQ/SEQ ever start APB activity.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB response codes driven on hresp.
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Bridge FSM states.
  //   IDLE   : nothing in flight, bridge ready
  //   WWAIT  : write accepted, waiting for hwdata in the AHB data phase
  //   SETUP  : APB setup phase (psel high, penable low)
  //   ACCESS : APB access phase (psel and penable high), waits on pready
  //   ERR1   : first ERROR cycle (hreadyout low)
  //   ERR2   : second ERROR cycle (hreadyout high)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridgeState_e;

  // Width of the slave-index field. A single slave still gets a one-bit
  // field so that an address with that bit set decodes as out of range.
  function automatic int selWidth(input int numSlaves);
    return (numSlaves <= 2) ? 1 : $clog2(numSlaves);
  endfunction

endpackage

// File: rtl/ahb_apb_decode.sv
// ---------------------------------------------------------------------------
// ahb_apb_decode
//
// Purely combinational slave decoder. Turns the slave-index field taken
// from haddr into a one-hot APB select vector and flags indices that do
// not correspond to any fitted slave.
//
// Ports:
//   idx_i  in   SEL_W       slave-index field, haddr[SEL_LSB +: SEL_W]
//   sel_o  out  NUM_SLAVES  one-hot select (all zero when out of range)
//   err_o  out  1           index >= NUM_SLAVES (decode error)
// ---------------------------------------------------------------------------
module ahb_apb_decode
  import ahb_apb_bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = selWidth(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      idx_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  err_o
);

  // Compare the index against every fitted slave number. An index that
  // matches none of them leaves the select vector empty, which is exactly
  // the decode-error condition, so the error flag falls out of the vector
  // rather than needing a separate magnitude compare.
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_i == SEL_W'(i)) begin
        sel_o[i] = 1'b1;
      end
    end
    err_o = (sel_o == '0);
  end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_p
//
// Parametrised AHB-Lite to APB bridge. One AHB transfer at a time is turned
// into an APB SETUP/ACCESS pair. Supports APB wait states (pready), slave
// errors (pslverr -> two-cycle AHB ERROR), address decode errors and an
// optional ACCESS-phase timeout.
//
// Parameters:
//   ADDR_W      address width (haddr/paddr)
//   DATA_W      data width (hwdata/hrdata/pwdata/prdata)
//   NUM_SLAVES  number of psel lines (1..16)
//   SEL_LSB     LSB of the slave-index field in haddr
//   TIMEOUT     max ACCESS cycles waiting for pready, 0 disables
//
// Ports:
//   hclk, hresetn          clock (rising edge), async active-low reset
//   hwrite, hreadyin,      AHB master side address phase
//   htrans, haddr
//   hwdata                 AHB write data (data phase)
//   hreadyout, hresp,      AHB response back to the master
//   hrdata
//   psel, penable, pwrite, APB master side
//   paddr, pwdata
//   prdata, pready,        APB slave response
//   pslverr
// ---------------------------------------------------------------------------
module ahb_apb_bridge_p
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_LSB    = 24,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic [ADDR_W-1:0]     haddr,
  input  logic [DATA_W-1:0]     hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_W-1:0]     hrdata,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int SEL_W = selWidth(NUM_SLAVES);

  // The wait counter only ever needs to reach TIMEOUT-1; the +2 keeps the
  // width at least one bit when the timeout is disabled.
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  bridgeState_e state_q, state_d;
  bridgeState_e acceptState;

  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [DATA_W-1:0]     hrdata_q, hrdata_d;
  logic [CNT_W-1:0]      waitCnt_q, waitCnt_d;

  logic [NUM_SLAVES-1:0] decodeSel;
  logic                  decodeErr;
  logic                  xferReq;
  logic                  timeoutHit;

  ahb_apb_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) uDecode (
    .idx_i (haddr[SEL_LSB +: SEL_W]),
    .sel_o (decodeSel),
    .err_o (decodeErr)
  );

  // A transfer is taken whenever the bus advances while the bridge itself is
  // ready. Because hreadyout is only high in IDLE, the completion cycle and
  // ERR2, this single term also covers back-to-back acceptance with no
  // separate "pipelined accept" path.
  assign xferReq = hreadyin && hreadyout &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // The timeout fires in the ACCESS cycle in which the counter shows that
  // TIMEOUT-1 wait cycles have already gone by, so psel drops after exactly
  // TIMEOUT ACCESS cycles.
  assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == CNT_LAST);

  // Next-state and datapath update. Address, direction and select are
  // captured on every accepted transfer regardless of the current state;
  // write data is captured during WWAIT, which is the AHB data phase of the
  // write. Read data is kept only from a clean completion so an errored
  // read leaves the previous hrdata intact.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    waitCnt_d = '0;

    if (decodeErr) begin
      acceptState = ST_ERR1;
    end else if (hwrite) begin
      acceptState = ST_WWAIT;
    end else begin
      acceptState = ST_SETUP;
    end

    if (xferReq) begin
      sel_d    = decodeSel;
      paddr_d  = haddr;
      pwrite_d = hwrite;
    end

    case (state_q)
      ST_IDLE: begin
        if (xferReq) begin
          state_d = acceptState;
        end
      end
      ST_WWAIT: begin
        pwdata_d = hwdata;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = ST_ERR1;
          end else begin
            if (!pwrite_q) begin
              hrdata_d = prdata;
            end
            state_d = xferReq ? acceptState : ST_IDLE;
          end
        end else if (timeoutHit) begin
          state_d = ST_ERR1;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        state_d = xferReq ? acceptState : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus-facing outputs are decoded from the state so that reset clears them
  // immediately. hreadyout and hrdata follow pready/prdata combinationally
  // in the completion cycle so the master sees the result with no extra
  // register stage; outside that cycle hrdata shows the held copy.
  always_comb begin
    psel      = '0;
    penable   = 1'b0;
    hreadyout = 1'b0;
    hresp     = HRESP_OKAY;
    hrdata    = hrdata_q;

    case (state_q)
      ST_IDLE: begin
        hreadyout = 1'b1;
      end
      ST_SETUP: begin
        psel = sel_q;
      end
      ST_ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        if (pready && !pslverr) begin
          hreadyout = 1'b1;
          if (!pwrite_q) begin
            hrdata = prdata;
          end
        end
      end
      ST_ERR1: begin
        hresp = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout = 1'b1;
        hresp     = HRESP_ERROR;
      end
      default: begin
      end
    endcase
  end

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;
  assign pwdata = pwdata_q;

  // State and datapath registers. Reset is asynchronous so the APB select
  // lines drop the moment hresetn falls, even mid-transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge_p
//
// Directed self-checking bench for ahb_apb_bridge_p with default parameters
// (3 slaves, slave index in haddr[25:24], TIMEOUT 16). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// busStat packs {psel[2:0], penable, hreadyout, hresp[1:0]}.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_p;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  int testsRun    = 0;
  int testsFailed = 0;

  wire [6:0] busStat = {psel, penable, hreadyout, hresp};

  ahb_apb_bridge_p #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .NUM_SLAVES (3),
    .SEL_LSB    (24),
    .TIMEOUT    (16)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hwrite    (hwrite),
    .hreadyin  (hreadyin),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // Free-running 10-unit clock.
  always #5 hclk = ~hclk;

  // Safety net so the run always ends even if the clock stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no summary, required finish before time limit");
    $fatal(1);
  end

  task automatic nextCycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic idleInputs();
    htrans   = 2'b00;
    hwrite   = 1'b0;
    hreadyin = 1'b1;
    pready   = 1'b1;
    pslverr  = 1'b0;
  endtask

  // Reset held low: every output at its reset value.
  task automatic test_reset();
    hresetn = 1'b0;
    idleInputs();
    haddr  = 32'h0;
    hwdata = 32'h0;
    prdata = 32'h0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctl: got %b required %b", busStat, 7'b0000100);
    end
    testsRun++;
    if ({pwrite, paddr, pwdata, hrdata} !== 97'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got %h required 0", {pwrite, paddr, pwdata, hrdata});
    end
    hresetn = 1'b1;
    nextCycle();
  endtask

  // Zero-wait write to slave 0: WWAIT, SETUP, complete at A+3.
  task automatic test_write();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0010;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL wr_accept: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000000) begin
      testsFailed++;
      $display("[TB] FAIL wr_wwait: got %b required %b", busStat, 7'b0000000);
    end
    nextCycle();
    hwdata = 32'h0;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0010000) begin
      testsFailed++;
      $display("[TB] FAIL wr_setup: got %b required %b", busStat, 7'b0010000);
    end
    testsRun++;
    if ({pwrite, paddr, pwdata} !== {1'b1, 32'h0000_0010, 32'hDEAD_BEEF}) begin
      testsFailed++;
      $display("[TB] FAIL wr_apb_bus: got %h required %h", {pwrite, paddr, pwdata},
               {1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0011100) begin
      testsFailed++;
      $display("[TB] FAIL wr_complete: got %b required %b", busStat, 7'b0011100);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if ({busStat, paddr, pwdata} !== {7'b0000100, 32'h0000_0010, 32'hDEAD_BEEF}) begin
      testsFailed++;
      $display("[TB] FAIL wr_idle_hold: got %h required %h", {busStat, paddr, pwdata},
               {7'b0000100, 32'h0000_0010, 32'hDEAD_BEEF});
    end
    nextCycle();
  endtask

  // Read slave 1 with two wait states; hrdata at A+4 and held afterwards.
  task automatic test_read_wait();
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0100_0004; pready = 1'b0;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL rd_accept: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
    htrans = 2'b00;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0100000) begin
      testsFailed++;
      $display("[TB] FAIL rd_setup: got %b required %b", busStat, 7'b0100000);
    end
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge hclk);
      testsRun++;
      if (busStat !== 7'b0101000) begin
        testsFailed++;
        $display("[TB] FAIL rd_wait%0d: got %b required %b", i, busStat, 7'b0101000);
      end
    end
    nextCycle();
    pready = 1'b1; prdata = 32'h1234_5678;
    @(negedge hclk);
    testsRun++;
    if ({busStat, hrdata} !== {7'b0101100, 32'h1234_5678}) begin
      testsFailed++;
      $display("[TB] FAIL rd_complete: got %h required %h", {busStat, hrdata},
               {7'b0101100, 32'h1234_5678});
    end
    nextCycle();
    prdata = 32'h0;
    @(negedge hclk);
    testsRun++;
    if ({busStat, hrdata} !== {7'b0000100, 32'h1234_5678}) begin
      testsFailed++;
      $display("[TB] FAIL rd_hrdata_held: got %h required %h", {busStat, hrdata},
               {7'b0000100, 32'h1234_5678});
    end
    nextCycle();
  endtask

  // Read slave 2 answering with pslverr: two-cycle ERROR, hrdata untouched.
  task automatic test_slverr();
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0200_0008;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL se_accept: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
    htrans = 2'b00;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b1000000) begin
      testsFailed++;
      $display("[TB] FAIL se_setup: got %b required %b", busStat, 7'b1000000);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b1001000) begin
      testsFailed++;
      $display("[TB] FAIL se_fault: got %b required %b", busStat, 7'b1001000);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000001) begin
      testsFailed++;
      $display("[TB] FAIL se_err1: got %b required %b", busStat, 7'b0000001);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if ({busStat, hrdata} !== {7'b0000101, 32'h1234_5678}) begin
      testsFailed++;
      $display("[TB] FAIL se_err2: got %h required %h", {busStat, hrdata},
               {7'b0000101, 32'h1234_5678});
    end
    nextCycle();
    pslverr = 1'b0; prdata = 32'h0;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL se_idle: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
  endtask

  // Slave index 3 with only 3 slaves: no psel, ERROR at A+1 and A+2.
  task automatic test_decode_err();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0300_0000;
    @(negedge hclk);
    nextCycle();
    htrans = 2'b00; hwrite = 1'b0;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000001) begin
      testsFailed++;
      $display("[TB] FAIL de_err1: got %b required %b", busStat, 7'b0000001);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000101) begin
      testsFailed++;
      $display("[TB] FAIL de_err2: got %b required %b", busStat, 7'b0000101);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL de_idle: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
  endtask

  // pready stuck low: 16 ACCESS cycles, then ERR1/ERR2.
  task automatic test_timeout();
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_0020; pready = 1'b0;
    @(negedge hclk);
    nextCycle();
    htrans = 2'b00;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0010000) begin
      testsFailed++;
      $display("[TB] FAIL to_setup: got %b required %b", busStat, 7'b0010000);
    end
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      @(negedge hclk);
      testsRun++;
      if (busStat !== 7'b0011000) begin
        testsFailed++;
        $display("[TB] FAIL to_access%0d: got %b required %b", i, busStat, 7'b0011000);
      end
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000001) begin
      testsFailed++;
      $display("[TB] FAIL to_err1: got %b required %b", busStat, 7'b0000001);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000101) begin
      testsFailed++;
      $display("[TB] FAIL to_err2: got %b required %b", busStat, 7'b0000101);
    end
    nextCycle();
    pready = 1'b1;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL to_idle: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
  endtask

  // BUSY and a NONSEQ with hreadyin low must not start anything.
  task automatic test_no_accept();
    htrans = 2'b01; hwrite = 1'b1; haddr = 32'h0000_0060;
    @(negedge hclk);
    nextCycle();
    htrans = 2'b10; hreadyin = 1'b0; haddr = 32'h0000_0070;
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL busy_okay: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
    htrans = 2'b00; hreadyin = 1'b1; hwrite = 1'b0;
    @(negedge hclk);
    testsRun++;
    if ({busStat, paddr} !== {7'b0000100, 32'h0000_0020}) begin
      testsFailed++;
      $display("[TB] FAIL no_capture: got %h required %h", {busStat, paddr},
               {7'b0000100, 32'h0000_0020});
    end
    nextCycle();
  endtask

  // Second write presented in the completion cycle of the first.
  task automatic test_back_to_back();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0030;
    @(negedge hclk);
    nextCycle();
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1111_1111;
    @(negedge hclk);
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0010000) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_setup: got %b required %b", busStat, 7'b0010000);
    end
    nextCycle();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0100_0040;
    @(negedge hclk);
    testsRun++;
    if ({busStat, pwdata} !== {7'b0011100, 32'h1111_1111}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_done: got %h required %h", {busStat, pwdata},
               {7'b0011100, 32'h1111_1111});
    end
    nextCycle();
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h2222_2222;
    @(negedge hclk);
    testsRun++;
    if ({busStat, paddr, pwrite} !== {7'b0000000, 32'h0100_0040, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_wwait: got %h required %h", {busStat, paddr, pwrite},
               {7'b0000000, 32'h0100_0040, 1'b1});
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if ({busStat, pwdata} !== {7'b0100000, 32'h2222_2222}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_setup: got %h required %h", {busStat, pwdata},
               {7'b0100000, 32'h2222_2222});
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0101100) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_done: got %b required %b", busStat, 7'b0101100);
    end
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
  endtask

  // hresetn dropped mid-ACCESS clears the APB bus without waiting for a clock.
  task automatic test_reset_mid();
    htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0000_0050; pready = 1'b0;
    @(negedge hclk);
    nextCycle();
    htrans = 2'b00;
    @(negedge hclk);
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0011000) begin
      testsFailed++;
      $display("[TB] FAIL rm_access: got %b required %b", busStat, 7'b0011000);
    end
    #1 hresetn = 1'b0;
    #1;
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL rm_reset_immediate: got %b required %b", busStat, 7'b0000100);
    end
    testsRun++;
    if ({paddr, pwdata, hrdata} !== 96'h0) begin
      testsFailed++;
      $display("[TB] FAIL rm_regs_cleared: got %h required 0", {paddr, pwdata, hrdata});
    end
    @(negedge hclk);
    hresetn = 1'b1;
    pready  = 1'b1;
    nextCycle();
    @(negedge hclk);
    testsRun++;
    if (busStat !== 7'b0000100) begin
      testsFailed++;
      $display("[TB] FAIL rm_after_release: got %b required %b", busStat, 7'b0000100);
    end
    nextCycle();
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_decode_err();
    test_timeout();
    test_no_accept();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
